latch_write_arbiter: RTL and testbench
======================================

// Module: latch_write_arbiter
// PURPOSE
//  Shares one WIDTH-bit bank of level-sensitive D latches (common d/en) among NREQ writers.
//  - Round-robin arbitration between requesters.
//  - Sequences each write as setup -> open -> hold, so latch data is stable whenever en is high.
//  - Sits between clocked requesters and the latch bank; the latches only ever see registered, glitch-free d/en.
// PARAMETERS
//  NREQ      4  number of requesters (2..8)
//  WIDTH     8  latch bank data width
//  OPEN_CYC  1  cycles lat_en is held high per write (1..15)
// PORTS
//  clk      in   1           system clock, rising edge
//  rst_n    in   1           asynchronous active-low reset
//  req      in   NREQ        write request per requester; held until its done pulse
//  wdata    in   NREQ*WIDTH  write data; requester i uses wdata[i*WIDTH +: WIDTH]
//  gnt      out  NREQ        one-hot grant; high from SETUP through HOLD
//  done     out  NREQ        one-cycle completion pulse to the granted requester
//  lat_d    out  WIDTH       data to latch bank d inputs (registered)
//  lat_en   out  1           latch bank enable (registered, glitch-free)
//  busy     out  1           high in any state other than IDLE
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the system): state=IDLE, gnt=0, done=0, lat_d=0,
//    lat_en=0, busy=0, rr pointer=NREQ-1 (so requester 0 wins first).
//  - All outputs are registered. No combinational path from req/wdata to lat_en/lat_d.
//  - States and transitions:
//    - IDLE:  if |req, pick winner (first set bit searching from pointer+1, wrapping);
//             register gnt[w], lat_d=wdata[w], pointer=w; -> SETUP.
//    - SETUP: lat_en<=1, load open counter=OPEN_CYC-1; -> OPEN.
//    - OPEN:  lat_en=1; decrement counter; at 0: lat_en<=0, done[w]<=1; -> HOLD.
//    - HOLD:  lat_en=0, lat_d unchanged, done[w]=1 for this cycle only;
//             gnt<=0, done<=0; -> IDLE.
//  - Timing: req sampled at edge t -> gnt and lat_d valid t+1, lat_en high t+2..t+1+OPEN_CYC,
//    done high in cycle t+2+OPEN_CYC. Next grant is no earlier than t+4+OPEN_CYC (one IDLE cycle).
//  - lat_d is stable one full cycle before lat_en rises and one full cycle after it falls.
//  - wdata is sampled only in IDLE; later changes are ignored for that write.
//  - req dropped mid-transaction: the write still completes and done still pulses (no abort).
//  - req newly raised while busy: waits. Simultaneous requests: round-robin order,
//    so no requester is starved while it holds req.
//  - Single requester holding req continuously: it is re-granted every 3+OPEN_CYC cycles.
//  - Reset mid-operation: lat_en drops immediately (async); the in-flight write is abandoned
//    and the latch contents are undefined to the system.
//  - OPEN_CYC outside 1..15 is a compile-time error.
// STRUCTURE
//  - Package latch_ctrl_pkg: state encodings (IDLE=2'd0, SETUP=2'd1, OPEN=2'd2, HOLD=2'd3)
//    and the counter width constant CNT_W=4.
//  - Sub-module rr_arbiter #(N): inputs req and ptr; outputs one-hot grant and the winner index.
//    Combinational; the winner is registered only in this block.
//  - This block holds the FSM, open counter, data mux/register, pointer and output registers.
// TESTING (bench instantiates dlatch x WIDTH on lat_d/lat_en)
//  1. rst_n=0 for 3 cycles mid-OPEN -> lat_en=0 at once, all outputs 0; first grant after reset goes to req0.
//  2. NREQ=4, OPEN_CYC=1, req=0001, wdata0=8'hA5 -> gnt=0001 @t+1, lat_en high only @t+2,
//     done0 @t+3, latch q=8'hA5.
//  3. req=1111 held -> grants in order 0,1,2,3,0, each 4 cycles apart; latched values match each wdata.
//  4. OPEN_CYC=3, req2 dropped during OPEN -> lat_en high exactly 3 cycles, done2 still pulses.
//  5. Change wdata1 from 8'h3C to 8'hFF after grant -> latch holds 8'h3C; lat_d never changes while lat_en=1.
//  6. Assertions: $onehot0(gnt); lat_d stable whenever lat_en or $past(lat_en); done implies gnt on the same bit.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// Shared encodings and constants for the latch write arbiter.
package latch_ctrl_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/latch_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] win_c
);

  always_comb begin
    int          pos;
    logic        found;
    logic [IW-1:0] sel;
    gnt_c = '0;
    win_c = '0;
    found = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int off = 1; off <= int'(N); off++) begin
      pos = int'(ptr) + off;
      if (pos >= int'(N)) pos = pos - int'(N);
      sel = IW'(pos);
      if (!found && req[sel]) begin
        found      = 1'b1;
        gnt_c[sel] = 1'b1;
        win_c      = sel;
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin writer arbitration for a shared latch bank; sequences setup -> open -> hold
// so the latches only ever see registered, glitch-free d/en.
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned OPEN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      lat_d,
  output logic                  lat_en,
  output logic                  busy
);

  localparam int unsigned IW = $clog2(NREQ);

  if (OPEN_CYC < 1 || OPEN_CYC > 15) begin : g_bad_open_cyc
    $error("latch_write_arbiter: OPEN_CYC must be in 1..15");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("latch_write_arbiter: NREQ must be in 2..8");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [WIDTH-1:0]   lat_d_q, lat_d_d;
  logic               lat_en_q, lat_en_d;
  logic               busy_q, busy_d;

  logic [NREQ-1:0]    arb_gnt_c;
  logic [IW-1:0]      arb_win_c;
  logic [WIDTH-1:0]   sel_data_c;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt_c (arb_gnt_c),
    .win_c (arb_win_c)
  );

  // Winner's data word; only captured in IDLE.
  always_comb begin
    sel_data_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (arb_gnt_c[i]) sel_data_c = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    lat_d_d  = lat_d_q;
    lat_en_d = lat_en_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = arb_gnt_c;
          lat_d_d = sel_data_c;
          ptr_d   = arb_win_c;
          state_d = SETUP;
        end
      end
      SETUP: begin
        lat_en_d = 1'b1;
        cnt_d    = CNT_W'(OPEN_CYC - 1);
        state_d  = OPEN;
      end
      OPEN: begin
        if (cnt_q == '0) begin
          lat_en_d = 1'b0;
          done_d   = gnt_q;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= IW'(NREQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign lat_d  = lat_d_q;
  assign lat_en = lat_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: two instances (OPEN_CYC=1 and 3) each driving a modelled latch bank.
module tb_latch_write_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_a, gnt_a, done_a;
  logic [NREQ*WIDTH-1:0] wdata_a;
  logic [WIDTH-1:0]      lat_d_a, q_a;
  logic                  lat_en_a, busy_a;

  logic [NREQ-1:0]       req_b, gnt_b, done_b;
  logic [NREQ*WIDTH-1:0] wdata_b;
  logic [WIDTH-1:0]      lat_d_b, q_b;
  logic                  lat_en_b, busy_b;

  latch_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPEN_CYC(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .wdata(wdata_a), .gnt(gnt_a),
    .done(done_a), .lat_d(lat_d_a), .lat_en(lat_en_a), .busy(busy_a)
  );

  latch_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPEN_CYC(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .wdata(wdata_b), .gnt(gnt_b),
    .done(done_b), .lat_d(lat_d_b), .lat_en(lat_en_b), .busy(busy_b)
  );

  // Latch bank models driven by the arbiters
  always_latch begin
    if (lat_en_a) q_a <= lat_d_a;
  end
  always_latch begin
    if (lat_en_b) q_b <= lat_d_b;
  end

  a_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_a));
  a_onehot_b: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_b));
  a_done_a:   assert property (@(posedge clk) disable iff (!rst_n) (done_a & ~gnt_a) == '0);
  a_done_b:   assert property (@(posedge clk) disable iff (!rst_n) (done_b & ~gnt_b) == '0);
  a_stab_a:   assert property (@(posedge clk) disable iff (!rst_n)
                               (lat_en_a || $past(lat_en_a)) |-> $stable(lat_d_a));
  a_stab_b:   assert property (@(posedge clk) disable iff (!rst_n)
                               (lat_en_b || $past(lat_en_b)) |-> $stable(lat_d_b));

  typedef struct packed {
    logic [1:0]       idx;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_n  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic set_wa(input int i, input logic [WIDTH-1:0] v);
    wdata_a[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic set_wb(input int i, input logic [WIDTH-1:0] v);
    wdata_b[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance at least one cycle until a grant is seen on the selected instance.
  task automatic wait_gnt(input bit use_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if ((use_b ? gnt_b : gnt_a) != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input bit use_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if ((use_b ? done_b : done_a) != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    n_chk++;
    if ({gnt_a, done_a, lat_d_a, lat_en_a, busy_a} !== '0)
      $display("FAIL reset_outputs got=%h want=0", {gnt_a, done_a, lat_d_a, lat_en_a, busy_a});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    set_wa(0, 8'h77);
    req_a = 4'b0001;
    cyc();
    cyc();
    n_chk++;
    if (lat_en_a !== 1'b1) $display("FAIL reset_pre_open lat_en got=%b want=1", lat_en_a);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({gnt_a, done_a, lat_d_a, lat_en_a, busy_a} !== '0)
      $display("FAIL reset_async got=%h want=0", {gnt_a, done_a, lat_d_a, lat_en_a, busy_a});
    else n_pass++;
    req_a = '0;
    repeat (3) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    req_a = 4'b1111;
    cyc();
    n_chk++;
    if (gnt_a !== 4'b0001) $display("FAIL reset_first_gnt got=%b want=0001", gnt_a);
    else n_pass++;
    req_a = '0;
    do_reset();
  endtask

  task automatic test_single();
    exp_t e;
    set_wa(0, 8'hA5);
    req_a = 4'b0001;
    cyc();
    n_chk++;
    if ({gnt_a, lat_d_a, lat_en_a, busy_a} !== {4'b0001, 8'hA5, 1'b0, 1'b1})
      $display("FAIL single_t1 got gnt=%b d=%h en=%b busy=%b want 0001/a5/0/1",
               gnt_a, lat_d_a, lat_en_a, busy_a);
    else n_pass++;
    sb_q.push_back('{idx: 2'd0, data: 8'hA5});
    cyc();
    n_chk++;
    if ({lat_en_a, done_a} !== {1'b1, 4'b0000})
      $display("FAIL single_t2 got en=%b done=%b want 1/0000", lat_en_a, done_a);
    else n_pass++;
    cyc();
    n_chk++;
    if ({lat_en_a, done_a} !== {1'b0, 4'b0001})
      $display("FAIL single_t3 got en=%b done=%b want 0/0001", lat_en_a, done_a);
    else n_pass++;
    req_a = '0;
    e = sb_q.pop_front();
    n_chk++;
    if (q_a !== e.data) $display("FAIL single_latch got=%h want=%h", q_a, e.data);
    else n_pass++;
    cyc();
    n_chk++;
    if ({gnt_a, done_a, busy_a} !== '0)
      $display("FAIL single_t4 got gnt=%b done=%b busy=%b want 0", gnt_a, done_a, busy_a);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit   ok;
    int   gcyc, prev;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_wa(i, WIDTH'(8'hC0 + i));
      sb_q.push_back('{idx: 2'(i), data: WIDTH'(8'hC0 + i)});
    end
    sb_q.push_back('{idx: 2'd0, data: 8'hD0});
    req_a = 4'b1111;
    prev  = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(1'b0, ok);
      gcyc = cyc_n;
      n_chk++;
      if (!ok) $display("FAIL rr_gnt_timeout round=%0d got=none want=grant", k);
      else n_pass++;
      n_chk++;
      if (gnt_a !== (4'b0001 << sb_q[0].idx))
        $display("FAIL rr_order round=%0d got=%b want=%b", k, gnt_a, 4'b0001 << sb_q[0].idx);
      else n_pass++;
      if (k > 0) begin
        n_chk++;
        if (gcyc - prev !== 4) $display("FAIL rr_spacing round=%0d got=%0d want=4", k, gcyc - prev);
        else n_pass++;
      end
      prev = gcyc;
      wait_done(1'b0, ok);
      e = sb_q.pop_front();
      n_chk++;
      if (!ok || done_a !== (4'b0001 << e.idx) || q_a !== e.data)
        $display("FAIL rr_write round=%0d got done=%b q=%h want done=%b q=%h",
                 k, done_a, q_a, 4'b0001 << e.idx, e.data);
      else n_pass++;
      if (k == 0) set_wa(0, 8'hD0);
      if (k == 4) req_a = '0;
    end
    cyc();
  endtask

  task automatic test_drop_mid_open();
    exp_t e;
    bit   ok, dropped;
    int   en_cnt, gcyc;
    set_wb(2, 8'h5A);
    req_b = 4'b0100;
    wait_gnt(1'b1, ok);
    gcyc = cyc_n;
    n_chk++;
    if (!ok || gnt_b !== 4'b0100) $display("FAIL drop_gnt got=%b want=0100", gnt_b);
    else n_pass++;
    sb_q.push_back('{idx: 2'd2, data: 8'h5A});
    en_cnt  = 0;
    dropped = 1'b0;
    ok      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (lat_en_b) begin
        en_cnt++;
        if (!dropped) begin
          req_b   = '0;
          dropped = 1'b1;
        end
      end
      if (done_b != '0) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (en_cnt !== 3) $display("FAIL drop_en_len got=%0d want=3", en_cnt);
    else n_pass++;
    n_chk++;
    if (!ok || done_b !== 4'b0100 || cyc_n - gcyc !== 4)
      $display("FAIL drop_done got done=%b lat=%0d want done=0100 lat=4", done_b, cyc_n - gcyc);
    else n_pass++;
    e = sb_q.pop_front();
    n_chk++;
    if (q_b !== e.data) $display("FAIL drop_latch got=%h want=%h", q_b, e.data);
    else n_pass++;
    repeat (2) cyc();
    n_chk++;
    if ({gnt_b, busy_b} !== '0) $display("FAIL drop_idle got gnt=%b busy=%b want 0", gnt_b, busy_b);
    else n_pass++;
  endtask

  task automatic test_wdata_change();
    exp_t e;
    bit   ok;
    set_wa(1, 8'h3C);
    req_a = 4'b0010;
    wait_gnt(1'b0, ok);
    n_chk++;
    if (!ok || gnt_a !== 4'b0010) $display("FAIL wchg_gnt got=%b want=0010", gnt_a);
    else n_pass++;
    sb_q.push_back('{idx: 2'd1, data: 8'h3C});
    set_wa(1, 8'hFF);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (lat_en_a) begin
        n_chk++;
        if (lat_d_a !== 8'h3C) $display("FAIL wchg_lat_d got=%h want=3c", lat_d_a);
        else n_pass++;
      end
      if (done_a != '0) begin
        ok = 1'b1;
        break;
      end
    end
    req_a = '0;
    e = sb_q.pop_front();
    n_chk++;
    if (!ok || q_a !== e.data) $display("FAIL wchg_latch got=%h want=%h", q_a, e.data);
    else n_pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    int   g0;
    set_wb(0, 8'h11);
    sb_q.push_back('{idx: 2'd0, data: 8'h11});
    sb_q.push_back('{idx: 2'd0, data: 8'h22});
    req_b = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      wait_gnt(1'b1, ok);
      n_chk++;
      if (!ok || gnt_b !== 4'b0001) $display("FAIL b2b_gnt round=%0d got=%b want=0001", k, gnt_b);
      else n_pass++;
      if (k == 1) begin
        n_chk++;
        if (cyc_n - g0 !== 6) $display("FAIL b2b_spacing got=%0d want=6", cyc_n - g0);
        else n_pass++;
      end
      g0 = cyc_n;
      wait_done(1'b1, ok);
      e = sb_q.pop_front();
      n_chk++;
      if (!ok || q_b !== e.data) $display("FAIL b2b_latch round=%0d got=%h want=%h", k, q_b, e.data);
      else n_pass++;
      set_wb(0, 8'h22);
      if (k == 1) req_b = '0;
    end
    cyc();
  endtask

  initial begin
    rst_n   = 1'b0;
    req_a   = '0;
    req_b   = '0;
    wdata_a = '0;
    wdata_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop_mid_open();
    test_wdata_change();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
